// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// uart_prog_loader_if : byte-strobe input and instruction-memory write port
// Revision: 1.0
// ============================================================================
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  // master: the loader itself; slave: the receiver/memory/CPU environment
  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_done, load_err
  );
  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_done, load_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// uart_prog_loader : frames UART bytes into a load packet and writes 32-bit
// words to instruction memory, holding the CPU until a full image is written.
// Optional checksum byte: `define UART_LOADER_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
module uart_prog_loader #(
  parameter int          ADDR_W         = 10,
  parameter int          BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  wire                  clk,
  input  wire                  reset,
  uart_prog_loader_if.master   bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t C_AFTER_DATA = S_CSUM;
`else
  localparam state_t C_AFTER_DATA = S_DONE;
`endif
  localparam int                C_TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TW-1:0]   C_TMO_LAST  = C_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] C_BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       C_MAX_WORDS = 32'((1 << ADDR_W) - BASE_ADDR);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_lane;
  logic [23:0]       r_word;
  logic [C_TW-1:0]   r_tmo;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_load_busy;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_waiting;
  logic              w_expired;
  logic              w_sync;
  logic [15:0]       w_len_full;

  assign w_waiting  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_expired  = w_waiting && !bus.rx_valid && (r_tmo == C_TMO_LAST);
  assign w_sync     = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_len_full = {bus.rx_data, r_len[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_word      <= '0;
      r_tmo       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
      r_mem_we    <= 1'b0;
      r_mem_addr  <= C_BASE;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      if (bus.rx_valid || !w_waiting) r_tmo <= '0;
      else if (!w_expired)           r_tmo <= r_tmo + 1'b1;

      if (w_expired) begin
        // partially assembled word is simply dropped with the lane reset
        r_state     <= S_ERR;
        r_lane      <= '0;
        r_load_err  <= 1'b1;
        r_load_busy <= 1'b0;
        r_cpu_hold  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_ERR: begin
            if (w_sync) begin
              r_state     <= S_LEN_LO;
              r_idx       <= '0;
              r_lane      <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum      <= '0;
`endif
              r_cpu_hold  <= 1'b1;
              r_load_err  <= 1'b0;
              r_load_busy <= 1'b1;
            end
          end
          S_LEN_LO: begin
            if (bus.rx_valid) begin
              r_len[7:0] <= bus.rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum     <= r_csum ^ bus.rx_data;
`endif
              r_state    <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (bus.rx_valid) begin
              r_len[15:8] <= bus.rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum      <= r_csum ^ bus.rx_data;
`endif
              if (w_len_full == 16'd0) begin
                r_state <= C_AFTER_DATA;
              end else if (32'(w_len_full) > C_MAX_WORDS) begin
                r_state     <= S_ERR;
                r_load_err  <= 1'b1;
                r_load_busy <= 1'b0;
                r_cpu_hold  <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.rx_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
              r_csum <= r_csum ^ bus.rx_data;
`endif
              r_lane <= r_lane + 2'd1;
              case (r_lane)
                2'd0: r_word[7:0]   <= bus.rx_data;
                2'd1: r_word[15:8]  <= bus.rx_data;
                2'd2: r_word[23:16] <= bus.rx_data;
                default: begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= C_BASE + r_idx[ADDR_W-1:0];
                  r_mem_wdata <= {bus.rx_data, r_word};
                  r_idx       <= r_idx + 1'b1;
                  if (32'(r_idx) + 32'd1 == 32'(r_len)) r_state <= C_AFTER_DATA;
                end
              endcase
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (bus.rx_valid) begin
              if (bus.rx_data == r_csum) begin
                r_state <= S_DONE;
              end else begin
                r_state     <= S_ERR;
                r_load_err  <= 1'b1;
                r_load_busy <= 1'b0;
                r_cpu_hold  <= 1'b1;
              end
            end
          end
`endif
          S_DONE: begin
            r_state     <= S_IDLE;
            r_load_done <= 1'b1;
            r_cpu_hold  <= 1'b0;
            r_load_busy <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_busy = r_load_busy;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_prog_loader : scoreboard bench; expected writes queued as bytes are sent
// Revision: 1.0
// ============================================================================
module tb_uart_prog_loader;
  localparam int         ADDR_W    = 4;
  localparam int         BASE_ADDR = 2;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         TMO       = 40;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          last_n = 0;
  wr_t         exp_q[$];
  logic [31:0] pkt[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write/done monitor on the falling edge
  logic prev_we = 1'b0, prev_rv = 1'b0, prev_done = 1'b0;
  wr_t  e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
        end
        check("we_latency", 64'(prev_rv), 1);
        check("we_back_to_back", 64'(prev_we), 0);
      end
      if (bus.load_done) begin
        done_cnt++;
        check("done_one_cycle", 64'(prev_done), 0);
`ifndef UART_LOADER_CHECKSUM_EN
        if (last_n != 0) check("done_after_last_write", 64'(prev_we), 1);
`endif
      end
    end
    prev_we   = bus.mem_we;
    prev_rv   = bus.rx_valid;
    prev_done = bus.load_done;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(SYNC);
    check("hold_on_sync", 64'(bus.cpu_hold), 1);
    check("busy_on_sync", 64'(bus.load_busy), 1);
    check("err_clr_on_sync", 64'(bus.load_err), 0);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_packet();
    logic [15:0] n;
    logic [7:0]  cs;
    logic [31:0] w;
    n      = 16'(pkt.size());
    last_n = pkt.size();
    send_hdr(n);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      exp_q.push_back('{ADDR_W'(BASE_ADDR + i), w});
      for (int k = 0; k < 4; k++) begin
        idle(int'($urandom_range(0, 2)));
        send_byte(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
    exp_done++;
    idle(4);
    check("sb_empty", 64'(exp_q.size()), 0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("hold_released", 64'(bus.cpu_hold), 0);
    check("busy_idle", 64'(bus.load_busy), 0);
    check("err_after_ok", 64'(bus.load_err), 0);
  endtask

  task automatic check_err_state(input string tag);
    idle(2);
    check({tag, "_err"}, 64'(bus.load_err), 1);
    check({tag, "_hold"}, 64'(bus.cpu_hold), 1);
    check({tag, "_busy"}, 64'(bus.load_busy), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_we", 64'(bus.mem_we), 0);
    check("rst_addr", 64'(bus.mem_addr), 64'(BASE_ADDR));
    check("rst_wdata", 64'(bus.mem_wdata), 0);
    check("rst_hold", 64'(bus.cpu_hold), 1);
    check("rst_busy", 64'(bus.load_busy), 0);
    check("rst_done", 64'(bus.load_done), 0);
    check("rst_err", 64'(bus.load_err), 0);
  endtask

  int cyc;
  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    idle(2);

    // two words, plus a word carrying the sync value as data
    pkt = '{32'h0000_0013, 32'h0010_0093};
    send_packet();
    pkt = '{32'hA5A5_A5A5};
    send_packet();

    // junk ahead of sync is ignored and does not re-assert hold
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(2);
    check("junk_hold", 64'(bus.cpu_hold), 0);
    check("junk_busy", 64'(bus.load_busy), 0);
    pkt = '{32'h1234_5678};
    send_packet();

    // empty image
    pkt.delete();
    send_packet();

    // inter-byte timeout inside a data word
    send_hdr(16'd1);
    send_byte(8'h11); send_byte(8'h22);
    cyc = 0;
    while (!bus.load_err && cyc < 3 * TMO) begin idle(1); cyc++; end
    check("timeout_cycles", 64'(cyc), 64'(TMO));
    check_err_state("timeout");
    pkt = '{32'hDEAD_BEEF};
    send_packet();

    // length boundary: 2**ADDR_W - BASE_ADDR words fit, one more does not
    send_hdr(16'(16 - BASE_ADDR + 1));
    check_err_state("len_over");
    for (int k = 0; k < 4; k++) send_byte(8'(k));
    idle(3);
    send_hdr(16'h0100);
    check_err_state("len_hi_over");
    pkt.delete();
    for (int i = 0; i < 16 - BASE_ADDR; i++) pkt.push_back($urandom);
    send_packet();

`ifdef UART_LOADER_CHECKSUM_EN
    send_hdr(16'd0);
    send_byte(8'h01);
    check_err_state("csum_bad");
`endif

    // reset in the middle of a word aborts without a write
    send_hdr(16'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1;
    #1;
    check_reset_vals();
    idle(2);
    reset = 1'b0;
    idle(1);
    send_byte(8'hCC); send_byte(8'hDD);
    idle(3);
    check("rst_abort_hold", 64'(bus.cpu_hold), 1);
    check("rst_abort_sb", 64'(exp_q.size()), 0);
    pkt = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
    send_packet();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
